// File: rtl/carfield_pkg.sv
// Shared definitions for the Carfield external address demux: downstream
// port indices, response codes, address map and the outstanding-txn default.
package carfield_pkg;

  typedef enum logic [2:0] {
    SlvL2Port1      = 3'd0,
    SlvL2Port2      = 3'd1,
    SlvSafetyIsland = 3'd2,
    SlvIntCluster   = 3'd3,
    SlvErr          = 3'd4
  } slv_idx_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExOkay = 2'd1,
    RespSlvErr = 2'd2,
    RespDecErr = 2'd3
  } resp_e;

  localparam int unsigned NumRegions     = 4;
  localparam int unsigned MaxTxnsDefault = 8;

  localparam logic [63:0] L2Port1Base      = 64'h0000_0000_7800_0000;
  localparam logic [63:0] L2Port2Base      = 64'h0000_0000_7820_0000;
  localparam logic [63:0] L2PortSize       = 64'h0000_0000_0020_0000;
  localparam logic [63:0] SafetyIslandBase = 64'h0000_0000_6000_0000;
  localparam logic [63:0] IntClusterBase   = 64'h0000_0000_5000_0000;
  localparam logic [63:0] IslandSize       = 64'h0000_0000_0080_0000;

  // True when addr falls in [Base, Base+Size) of region idx; unknown indices never hit.
  function automatic logic region_hit(input logic [63:0] addr, input int unsigned idx);
    logic [63:0] base;
    logic [63:0] size;
    logic        known;
    base  = '0;
    size  = '0;
    known = 1'b1;
    case (idx)
      int'(SlvL2Port1):      begin base = L2Port1Base;      size = L2PortSize; end
      int'(SlvL2Port2):      begin base = L2Port2Base;      size = L2PortSize; end
      int'(SlvSafetyIsland): begin base = SafetyIslandBase; size = IslandSize; end
      int'(SlvIntCluster):   begin base = IntClusterBase;   size = IslandSize; end
      default:               known = 1'b0;
    endcase
    return known && (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/carfield_ext_demux_order_fifo.sv
// Order FIFO for the external demux: remembers {target, id} per accepted
// request so responses are returned in acceptance order. Depth must be a
// power of two (>= 2); pointers carry one wrap bit to tell full from empty.
module carfield_ext_demux_order_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wptr;
  logic [PtrW:0]    rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PtrW] != rptr[PtrW]) && (wptr[PtrW-1:0] == rptr[PtrW-1:0]);
  assign rdata = mem[rptr[PtrW-1:0]];

  // Storage write; blocked when full so a stalled push cannot clobber the head.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[PtrW-1:0]] <= wdata;
    end
  end

  // Read/write pointers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/carfield_ext_addr_demux.sv
// Carfield external address demux: routes one upstream request stream to
// NumSlv downstream ports by address, answers unmapped addresses with DECERR
// and returns responses in acceptance order.
// Optional feature macro: CARFIELD_EXT_DEMUX_DECERR_CNT_EN adds a saturating
// decode-error counter and last-error-address outputs.
module carfield_ext_addr_demux
  import carfield_pkg::*;
#(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned NumSlv    = 4,
  parameter int unsigned MaxTxns   = MaxTxnsDefault
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic                        req_write_i,
  input  logic [DataWidth-1:0]        req_wdata_i,
  input  logic [IdWidth-1:0]          req_id_i,
  output logic [NumSlv-1:0]           slv_req_valid_o,
  input  logic [NumSlv-1:0]           slv_req_ready_i,
  output logic [AddrWidth-1:0]        slv_req_addr_o,
  output logic                        slv_req_write_o,
  output logic [DataWidth-1:0]        slv_req_wdata_o,
  input  logic [NumSlv-1:0]           slv_rsp_valid_i,
  output logic [NumSlv-1:0]           slv_rsp_ready_o,
  input  logic [NumSlv*DataWidth-1:0] slv_rsp_rdata_i,
  input  logic [NumSlv-1:0]           slv_rsp_err_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  output logic [1:0]                  rsp_resp_o,
  output logic [IdWidth-1:0]          rsp_id_o
`ifdef CARFIELD_EXT_DEMUX_DECERR_CNT_EN
  ,
  output logic [15:0]                 decerr_cnt_o,
  output logic [AddrWidth-1:0]        decerr_addr_o
`endif
);

  localparam int unsigned    TgtW   = $clog2(NumSlv + 1);
  localparam int unsigned    EntryW = TgtW + IdWidth;
  localparam logic [TgtW-1:0] TgtErr = TgtW'(NumSlv);

  logic              rst_q;
  logic              block;
  logic [63:0]       addr_ext;
  logic [TgtW-1:0]   target;
  logic              found;
  logic              tgt_ready;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] head;
  logic [TgtW-1:0]   head_tgt;

  // Remembers reset for one extra cycle so handshakes stay quiet right after release.
  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
  end

  assign block    = rst_i | rst_q;
  assign addr_ext = 64'(req_addr_i);

  // Address decode: lowest matching region index wins, no match targets ERR.
  always_comb begin
    target = TgtErr;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumSlv; i++) begin
      if (!found && region_hit(addr_ext, i)) begin
        found  = 1'b1;
        target = TgtW'(i);
      end
    end
  end

  // Request steering: a full order FIFO stalls everything, even when a pop is pending.
  always_comb begin
    slv_req_valid_o = '0;
    tgt_ready       = 1'b0;
    for (int unsigned i = 0; i < NumSlv; i++) begin
      if (target == TgtW'(i)) begin
        tgt_ready          = slv_req_ready_i[i];
        slv_req_valid_o[i] = req_valid_i && !full && !block;
      end
    end
    if (target == TgtErr) tgt_ready = 1'b1;
    req_ready_o = !full && !block && tgt_ready;
  end

  assign push            = req_valid_i && req_ready_o;
  assign slv_req_addr_o  = req_addr_i;
  assign slv_req_write_o = req_write_i;
  assign slv_req_wdata_o = req_wdata_i;

  carfield_ext_demux_order_fifo #(
    .Width (EntryW),
    .Depth (MaxTxns)
  ) i_order_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata ({target, req_id_i}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign head_tgt = head[EntryW-1:IdWidth];
  assign rsp_id_o = head[IdWidth-1:0];

  // Response path: only the FIFO head target may hand back a response.
  always_comb begin
    rsp_valid_o     = 1'b0;
    slv_rsp_ready_o = '0;
    rsp_rdata_o     = '0;
    rsp_resp_o      = RespOkay;
    if (!empty && !block) begin
      if (head_tgt == TgtErr) begin
        rsp_valid_o = 1'b1;
        rsp_resp_o  = RespDecErr;
      end else begin
        for (int unsigned i = 0; i < NumSlv; i++) begin
          if (head_tgt == TgtW'(i)) begin
            rsp_valid_o        = slv_rsp_valid_i[i];
            slv_rsp_ready_o[i] = rsp_ready_i;
            rsp_rdata_o        = slv_rsp_rdata_i[i*DataWidth +: DataWidth];
            rsp_resp_o         = slv_rsp_err_i[i] ? RespSlvErr : RespOkay;
          end
        end
      end
    end
  end

  assign pop = rsp_valid_o && rsp_ready_i;

`ifdef CARFIELD_EXT_DEMUX_DECERR_CNT_EN
  // Decode-error statistics: saturating count and address of the latest ERR acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      decerr_cnt_o  <= '0;
      decerr_addr_o <= '0;
    end else if (push && (target == TgtErr)) begin
      if (decerr_cnt_o != '1) decerr_cnt_o <= decerr_cnt_o + 16'd1;
      decerr_addr_o <= req_addr_i;
    end
  end
`endif

endmodule

// File: tb/tb_carfield_ext_addr_demux.sv
// Self-checking bench for carfield_ext_addr_demux: directed scenarios plus a
// randomized phase, all checked every cycle against a queue-based model of
// the address map and in-order response rules.
module tb_carfield_ext_addr_demux;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [47:0]  req_addr;
  logic         req_write;
  logic [63:0]  req_wdata;
  logic [1:0]   req_id;
  logic [3:0]   slv_req_valid;
  logic [3:0]   slv_req_ready;
  logic [47:0]  slv_req_addr;
  logic         slv_req_write;
  logic [63:0]  slv_req_wdata;
  logic [3:0]   slv_rsp_valid;
  logic [3:0]   slv_rsp_ready;
  logic [255:0] slv_rsp_rdata;
  logic [3:0]   slv_rsp_err;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_rdata;
  logic [1:0]   rsp_resp;
  logic [1:0]   rsp_id;
`ifdef CARFIELD_EXT_DEMUX_DECERR_CNT_EN
  logic [15:0]  decerr_cnt;
  logic [47:0]  decerr_addr;
`endif

  always #5 clk = ~clk;

  carfield_ext_addr_demux #(
    .AddrWidth (48),
    .DataWidth (64),
    .IdWidth   (2),
    .NumSlv    (4),
    .MaxTxns   (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_write_i     (req_write),
    .req_wdata_i     (req_wdata),
    .req_id_i        (req_id),
    .slv_req_valid_o (slv_req_valid),
    .slv_req_ready_i (slv_req_ready),
    .slv_req_addr_o  (slv_req_addr),
    .slv_req_write_o (slv_req_write),
    .slv_req_wdata_o (slv_req_wdata),
    .slv_rsp_valid_i (slv_rsp_valid),
    .slv_rsp_ready_o (slv_rsp_ready),
    .slv_rsp_rdata_i (slv_rsp_rdata),
    .slv_rsp_err_i   (slv_rsp_err),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_resp_o      (rsp_resp),
    .rsp_id_o        (rsp_id)
`ifdef CARFIELD_EXT_DEMUX_DECERR_CNT_EN
    ,
    .decerr_cnt_o    (decerr_cnt),
    .decerr_addr_o   (decerr_addr)
`endif
  );

  // Reference model state
  typedef struct {
    int         tgt;
    logic [1:0] id;
  } ent_t;

  ent_t        oq[$];
  bit          prev_rst = 1'b0;
  int unsigned m_cnt    = 0;
  logic [47:0] m_addr   = '0;
  int          checks   = 0;
  int          failures = 0;

  // Address map straight from the region table: 4 means "no region".
  function automatic int tb_decode(input logic [47:0] a);
    if (a >= 48'h7800_0000 && a < 48'h7820_0000) return 0;
    if (a >= 48'h7820_0000 && a < 48'h7840_0000) return 1;
    if (a >= 48'h6000_0000 && a < 48'h6080_0000) return 2;
    if (a >= 48'h5000_0000 && a < 48'h5080_0000) return 3;
    return 4;
  endfunction

  function automatic logic [47:0] rand_addr();
    logic [47:0] bases [4];
    logic [47:0] sizes [4];
    int          r;
    bases = '{48'h7800_0000, 48'h7820_0000, 48'h6000_0000, 48'h5000_0000};
    sizes = '{48'h20_0000, 48'h20_0000, 48'h80_0000, 48'h80_0000};
    r = int'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0:       return bases[r];
      1:       return bases[r] + sizes[r] - 48'd1;
      2:       return bases[r] + sizes[r];
      3:       return bases[r] - 48'd1;
      4:       return bases[r] + 48'($urandom % 32'(sizes[r]));
      default: return {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic step();
    int          tgt;
    int          h;
    bit          blk;
    bit          full;
    bit          acc;
    bit          popm;
    bit          e_rr;
    bit          e_rv;
    logic [3:0]  e_sreqv;
    logic [3:0]  e_srspr;
    logic [1:0]  e_resp;
    logic [63:0] e_rdata;
    logic [1:0]  e_id;
    @(negedge clk);
    blk     = rst || prev_rst;
    full    = (oq.size() == 8);
    tgt     = tb_decode(req_addr);
    e_rr    = !blk && !full && (tgt == 4 || slv_req_ready[tgt] == 1'b1);
    e_sreqv = '0;
    if (req_valid && !blk && !full && tgt < 4) e_sreqv[tgt] = 1'b1;
    e_rv    = 1'b0;
    e_srspr = '0;
    e_resp  = 2'd0;
    e_rdata = '0;
    e_id    = '0;
    if (!blk && oq.size() > 0) begin
      e_id = oq[0].id;
      if (oq[0].tgt == 4) begin
        e_rv   = 1'b1;
        e_resp = 2'd3;
      end else begin
        h          = oq[0].tgt;
        e_rv       = slv_rsp_valid[h];
        e_srspr[h] = rsp_ready;
        e_resp     = slv_rsp_err[h] ? 2'd2 : 2'd0;
        e_rdata    = slv_rsp_rdata[h*64 +: 64];
      end
    end
    chk("req_ready", 64'(req_ready), 64'(e_rr));
    chk("slv_req_valid", 64'(slv_req_valid), 64'(e_sreqv));
    chk("slv_req_addr", 64'(slv_req_addr), 64'(req_addr));
    chk("slv_req_write", 64'(slv_req_write), 64'(req_write));
    chk("slv_req_wdata", slv_req_wdata, req_wdata);
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("slv_rsp_ready", 64'(slv_rsp_ready), 64'(e_srspr));
    if (e_rv) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_resp", 64'(rsp_resp), 64'(e_resp));
      chk("rsp_id", 64'(rsp_id), 64'(e_id));
    end
`ifdef CARFIELD_EXT_DEMUX_DECERR_CNT_EN
    chk("decerr_cnt", 64'(decerr_cnt), 64'(m_cnt));
    chk("decerr_addr", 64'(decerr_addr), 64'(m_addr));
`endif
    acc  = req_valid && e_rr;
    popm = e_rv && rsp_ready;
    @(posedge clk);
    if (rst) begin
      oq.delete();
      m_cnt  = 0;
      m_addr = '0;
    end else begin
      if (popm) void'(oq.pop_front());
      if (acc) begin
        oq.push_back('{tgt: tgt, id: req_id});
        if (tgt == 4) begin
          if (m_cnt < 65535) m_cnt++;
          m_addr = req_addr;
        end
      end
    end
    prev_rst = rst;
    #1;
  endtask

  task automatic set_req(input logic [47:0] a, input logic w, input logic [1:0] id);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = {$urandom, $urandom};
    req_id    = id;
  endtask

  task automatic rand_rdata();
    for (int i = 0; i < 4; i++) slv_rsp_rdata[i*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic idle();
    req_valid     = 1'b0;
    slv_req_ready = 4'hF;
    slv_rsp_valid = '0;
    slv_rsp_err   = '0;
    rsp_ready     = 1'b1;
  endtask

  // Every slave answers every cycle until the order FIFO has drained.
  task automatic drain();
    idle();
    slv_rsp_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      rand_rdata();
      step();
    end
    idle();
  endtask

  initial begin
    rst           = 1'b1;
    req_addr      = '0;
    req_write     = 1'b0;
    req_wdata     = '0;
    req_id        = '0;
    slv_rsp_rdata = '0;
    idle();

    // Reset, then a request in the first cycle after release must still stall
    step();
    step();
    rst = 1'b0;
    set_req(48'h7800_0000, 1'b0, 2'd0);
    step();
    idle();
    step();

    // Write to L2 port 1 with OKAY response
    set_req(48'h7800_0010, 1'b1, 2'd1);
    step();
    idle();
    step();
    slv_rsp_valid[0] = 1'b1;
    rand_rdata();
    step();
    idle();
    step();

    // Last byte of the cluster region, then first byte past it
    set_req(48'h507F_FFFF, 1'b0, 2'd2);
    step();
    set_req(48'h5080_0000, 1'b0, 2'd3);
    step();
    idle();
    step();
    step();
    slv_rsp_valid[3] = 1'b1;
    rand_rdata();
    step();
    idle();
    step();
    step();

    // Fill the order FIFO, ninth request stalls until a pop frees a slot
    for (int i = 0; i < 8; i++) begin
      set_req(48'h6000_0000, 1'b0, 2'(i));
      slv_rsp_valid = '0;
      step();
    end
    set_req(48'h6000_0000, 1'b1, 2'd0);
    step();
    step();
    slv_rsp_valid[2] = 1'b1;
    slv_rsp_err[2]   = 1'b1;
    rand_rdata();
    step();
    slv_rsp_valid = '0;
    slv_rsp_err   = '0;
    step();
    drain();

    // Out-of-order slave response is held until the older one returns
    set_req(48'h6000_0000, 1'b0, 2'd1);
    step();
    set_req(48'h7800_0000, 1'b0, 2'd2);
    step();
    idle();
    slv_rsp_valid[0] = 1'b1;
    rand_rdata();
    step();
    step();
    slv_rsp_valid[2] = 1'b1;
    step();
    slv_rsp_valid[2] = 1'b0;
    step();
    idle();
    step();

    // Reset with three outstanding, late slave response must be ignored
    for (int i = 0; i < 3; i++) begin
      set_req(48'h7820_0000 + 48'(i * 8), 1'b0, 2'(i));
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    slv_rsp_valid[1] = 1'b1;
    step();
    slv_rsp_valid = '0;
    step();
    set_req(48'h7820_0000, 1'b1, 2'd2);
    step();
    idle();
    slv_rsp_valid[1] = 1'b1;
    rand_rdata();
    step();
    idle();
    step();

    // Three unmapped requests feed the decode-error statistics
    for (int i = 0; i < 3; i++) begin
      set_req(48'h0000_1000, 1'b0, 2'(i));
      rsp_ready = 1'b0;
      step();
    end
    idle();
    step();
    drain();
    step();

    // Randomized traffic including slave backpressure and random responses
    for (int n = 0; n < 600; n++) begin
      req_valid     = ($urandom_range(0, 9) < 6);
      req_addr      = rand_addr();
      req_write     = 1'($urandom);
      req_wdata     = {$urandom, $urandom};
      req_id        = 2'($urandom);
      slv_req_ready = 4'($urandom);
      slv_rsp_valid = 4'($urandom);
      slv_rsp_err   = 4'($urandom);
      rsp_ready     = ($urandom_range(0, 3) != 0);
      rand_rdata();
      rst           = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
